set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache.sv | 202 ++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: write-through, no-write-allocate set-associative cache (1 or 2 ways, LRU)
// Ports:
//   clock, rst                     - rising-edge clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/wdata  - CPU request (word address), accepted only in IDLE
//   cpu_rdata, cpu_ready           - read data and one-cycle completion pulse
//   hit, miss                      - one-cycle lookup result pulses
//   mem_req/mem_we/mem_addr/wdata  - memory request, held until mem_ready
//   mem_rdata, mem_ready           - refill block (word 0 in [31:0]) and accept strobe
//   hit_count, miss_count          - saturating 16-bit statistics
module set_assoc_cache #(
    parameter int ADDR_W = 15,
    parameter int WORDS  = 4,
    parameter int SETS   = 256,
    parameter int WAYS   = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  hit,
    output logic                  miss,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [2:0] {IDLE, COMPARE, REFILL, WRITE_MEM, DONE} state_t;

    state_t              r_state;
    logic [32*WORDS-1:0] r_data  [WAYS][SETS];
    logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
    logic [SETS-1:0]     r_valid [WAYS];
    logic [SETS-1:0]     r_lru;
    logic                r_we;
    logic                r_way;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_cpu_rdata;
    logic                r_cpu_ready;
    logic                r_hit;
    logic                r_miss;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [15:0]         r_hit_count;
    logic [15:0]         r_miss_count;

    logic [OFF_W-1:0]    w_c_off, w_r_off;
    logic [IDX_W-1:0]    w_c_idx, w_r_idx;
    logic [TAG_W-1:0]    w_c_tag, w_r_tag;
    logic                w_any;
    logic                w_hit_way;
    logic                w_victim;
    logic [31:0]         w_hit_word;
    logic [31:0]         w_refill_word;

    assign w_c_off = cpu_addr[OFF_W-1:0];
    assign w_c_idx = cpu_addr[OFF_W +: IDX_W];
    assign w_c_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_r_off = r_addr[OFF_W-1:0];
    assign w_r_idx = r_addr[OFF_W +: IDX_W];
    assign w_r_tag = r_addr[ADDR_W-1 -: TAG_W];

    // Lookup runs on the incoming address so hit/miss/cpu_ready can be
    // registered into the COMPARE cycle.
    always_comb begin
        w_any     = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_c_idx] && r_tag[w][w_c_idx] == w_c_tag) begin
                w_any     = 1'b1;
                w_hit_way = 1'(w);
            end
        end
    end

    // Victim: first invalid way (way 0 preferred), otherwise the LRU way.
    always_comb begin
        w_victim = (WAYS == 2) ? r_lru[w_r_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_r_idx])
                w_victim = 1'(w);
        end
    end

    assign w_hit_word    = r_data[w_hit_way][w_c_idx][{w_c_off, 5'b0} +: 32];
    assign w_refill_word = mem_rdata[{w_r_off, 5'b0} +: 32];

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= IDLE;
            for (int w = 0; w < WAYS; w++)
                r_valid[w] <= '0;
            r_lru        <= '0;
            r_we         <= 1'b0;
            r_way        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_ready  <= 1'b0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_cpu_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_way   <= w_hit_way;
                        r_hit   <= w_any;
                        r_miss  <= !w_any;
                        if (w_any) begin
                            r_lru[w_c_idx] <= ~w_hit_way;
                            if (r_hit_count != 16'hFFFF)
                                r_hit_count <= r_hit_count + 16'd1;
                        end else if (r_miss_count != 16'hFFFF) begin
                            r_miss_count <= r_miss_count + 16'd1;
                        end
                        if (w_any && !cpu_we) begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= w_hit_word;
                        end
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (r_we) begin
                        if (r_hit)
                            r_data[r_way][w_r_idx][{w_r_off, 5'b0} +: 32] <= r_wdata;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= WRITE_MEM;
                    end else if (r_hit) begin
                        r_state <= IDLE;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_r_tag, w_r_idx, {OFF_W{1'b0}}};
                        r_state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        r_data[w_victim][w_r_idx]  <= mem_rdata;
                        r_tag[w_victim][w_r_idx]   <= w_r_tag;
                        r_valid[w_victim][w_r_idx] <= 1'b1;
                        r_lru[w_r_idx]             <= ~w_victim;
                        r_cpu_rdata                <= w_refill_word;
                        r_mem_req                  <= 1'b0;
                        r_cpu_ready                <= 1'b1;
                        r_state                    <= DONE;
                    end
                end
                WRITE_MEM: begin
                    if (mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ready  = r_cpu_ready;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed table-driven bench for set_assoc_cache with a small memory responder
module tb_set_assoc_cache;
    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [14:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         hit;
    logic         miss;
    logic         mem_req;
    logic         mem_we;
    logic [14:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] tbmem [logic [14:0]];

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [14:0] maddr;
        logic [31:0] rdata;
        logic [15:0] hc;
        logic [15:0] mc;
    } vec_t;

    vec_t vt [15];

    set_assoc_cache dut (
        .clock(clock), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit), .miss(miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [14:0] a);
        if (tbmem.exists(a))
            return tbmem[a];
        return (a == 15'h0405) ? 32'hDEADBEEF : {16'hC0DE, 1'b0, a};
    endfunction

    task automatic run(input vec_t v, input string nm);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        @(negedge clock);
        cpu_req = 1'b0;
        chk({nm, "_hit"}, 32'(hit), 32'(v.hit));
        chk({nm, "_miss"}, 32'(miss), 32'(!v.hit));
        chk({nm, "_cmp_ready"}, 32'(cpu_ready), 32'(v.hit && !v.we));
        chk({nm, "_cmp_memreq"}, 32'(mem_req), 32'd0);
        if (v.hit && !v.we) begin
            chk({nm, "_rdata"}, cpu_rdata, v.rdata);
            chk({nm, "_hc"}, 32'(hit_count), 32'(v.hc));
            chk({nm, "_mc"}, 32'(miss_count), 32'(v.mc));
            @(negedge clock);
            chk({nm, "_idle_memreq"}, 32'(mem_req), 32'd0);
            chk({nm, "_idle_ready"}, 32'(cpu_ready), 32'd0);
        end else begin
            @(negedge clock);
            chk({nm, "_memreq"}, 32'(mem_req), 32'd1);
            chk({nm, "_memwe"}, 32'(mem_we), 32'(v.we));
            chk({nm, "_memaddr"}, 32'(mem_addr), 32'(v.maddr));
            if (v.we)
                chk({nm, "_memwdata"}, mem_wdata, v.wdata);
            @(negedge clock);
            chk({nm, "_memreq_held"}, 32'(mem_req), 32'd1);
            chk({nm, "_wait_ready"}, 32'(cpu_ready), 32'd0);
            if (v.we)
                tbmem[v.addr] = v.wdata;
            for (int k = 0; k < 4; k++)
                mem_rdata[32*k +: 32] = word(15'(v.maddr + 15'(k)));
            mem_ready = 1'b1;
            @(negedge clock);
            mem_ready = 1'b0;
            chk({nm, "_done_ready"}, 32'(cpu_ready), 32'd1);
            chk({nm, "_done_memreq"}, 32'(mem_req), 32'd0);
            if (!v.we)
                chk({nm, "_rdata"}, cpu_rdata, v.rdata);
            chk({nm, "_hc"}, 32'(hit_count), 32'(v.hc));
            chk({nm, "_mc"}, 32'(miss_count), 32'(v.mc));
            @(negedge clock);
            chk({nm, "_after_ready"}, 32'(cpu_ready), 32'd0);
        end
    endtask

    initial begin
        vec_t sv;
        vt[0]  = '{1'b0, 15'h0405, 32'h0, 1'b0, 15'h0404, 32'hDEADBEEF, 16'd0, 16'd1};
        vt[1]  = '{1'b0, 15'h0407, 32'h0, 1'b1, 15'h0000, 32'hC0DE0407, 16'd1, 16'd1};
        vt[2]  = '{1'b0, 15'h0014, 32'h0, 1'b0, 15'h0014, 32'hC0DE0014, 16'd1, 16'd2};
        vt[3]  = '{1'b0, 15'h0414, 32'h0, 1'b0, 15'h0414, 32'hC0DE0414, 16'd1, 16'd3};
        vt[4]  = '{1'b0, 15'h0814, 32'h0, 1'b0, 15'h0814, 32'hC0DE0814, 16'd1, 16'd4};
        vt[5]  = '{1'b0, 15'h0414, 32'h0, 1'b1, 15'h0000, 32'hC0DE0414, 16'd2, 16'd4};
        vt[6]  = '{1'b0, 15'h0014, 32'h0, 1'b0, 15'h0014, 32'hC0DE0014, 16'd2, 16'd5};
        vt[7]  = '{1'b0, 15'h0414, 32'h0, 1'b1, 15'h0000, 32'hC0DE0414, 16'd3, 16'd5};
        vt[8]  = '{1'b0, 15'h0814, 32'h0, 1'b0, 15'h0814, 32'hC0DE0814, 16'd3, 16'd6};
        vt[9]  = '{1'b1, 15'h0405, 32'h12345678, 1'b1, 15'h0405, 32'h0, 16'd4, 16'd6};
        vt[10] = '{1'b0, 15'h0405, 32'h0, 1'b1, 15'h0000, 32'h12345678, 16'd5, 16'd6};
        vt[11] = '{1'b1, 15'h7FFC, 32'hAABBCCDD, 1'b0, 15'h7FFC, 32'h0, 16'd5, 16'd7};
        vt[12] = '{1'b0, 15'h7FFC, 32'h0, 1'b0, 15'h7FFC, 32'hAABBCCDD, 16'd5, 16'd8};
        vt[13] = '{1'b0, 15'h7FFD, 32'h0, 1'b1, 15'h0000, 32'hC0DE7FFD, 16'd6, 16'd8};
        vt[14] = '{1'b0, 15'h0406, 32'h0, 1'b1, 15'h0000, 32'hC0DE0406, 16'd7, 16'd8};

        repeat (2) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_hitmiss", 32'({hit, miss}), 32'd0);
        chk("rst_memreq", 32'({mem_req, mem_we}), 32'd0);
        chk("rst_counts", {hit_count, miss_count}, 32'd0);

        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD0BAD0}};
        repeat (2) @(negedge clock);
        mem_ready = 1'b0;
        chk("idle_memready_ready", 32'(cpu_ready), 32'd0);
        chk("idle_memready_memreq", 32'(mem_req), 32'd0);

        for (int i = 0; i < 15; i++)
            run(vt[i], $sformatf("v%0d", i));

        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0500;
        @(negedge clock);
        cpu_req = 1'b0;
        chk("rr_miss", 32'(miss), 32'd1);
        @(negedge clock);
        chk("rr_memreq", 32'(mem_req), 32'd1);
        rst = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = {4{32'h5A5A5A5A}};
        @(negedge clock);
        rst = 1'b0;
        mem_ready = 1'b0;
        chk("rr_memreq_drop", 32'(mem_req), 32'd0);
        chk("rr_ready", 32'(cpu_ready), 32'd0);
        chk("rr_counts", {hit_count, miss_count}, 32'd0);
        @(negedge clock);
        chk("rr_ready2", 32'(cpu_ready), 32'd0);
        sv = '{1'b0, 15'h0500, 32'h0, 1'b0, 15'h0500, 32'hC0DE0500, 16'd0, 16'd1};
        run(sv, "rr_reread");

        @(negedge clock);
        force dut.r_hit_count = 16'hFFFD;
        #1;
        release dut.r_hit_count;
        sv = '{1'b0, 15'h0501, 32'h0, 1'b1, 15'h0000, 32'hC0DE0501, 16'hFFFE, 16'd1};
        run(sv, "sat0");
        sv = '{1'b0, 15'h0502, 32'h0, 1'b1, 15'h0000, 32'hC0DE0502, 16'hFFFF, 16'd1};
        run(sv, "sat1");
        sv = '{1'b0, 15'h0503, 32'h0, 1'b1, 15'h0000, 32'hC0DE0503, 16'hFFFF, 16'd1};
        run(sv, "sat2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
